// File: rtl/mux2_rr_arbiter_if.sv
// mux2_rr_arbiter_if: two upstream valid/data/last/ready streams, one downstream stream, grant status
// Ports: in0_*/in1_* upstream streams, out_* downstream stream, sel (grant/mux select), busy (grant held).
// The master modport is the arbiter's view; slave is the producers/consumer side.
interface mux2_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_last;
    logic             in0_ready;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_last;
    logic             in1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;
    logic             sel;
    logic             busy;
    modport master (
        input  in0_valid, in0_data, in0_last, in1_valid, in1_data, in1_last, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, out_last, sel, busy
    );
    modport slave (
        output in0_valid, in0_data, in0_last, in1_valid, in1_data, in1_last, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, out_last, sel, busy
    );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: two-requester round-robin arbiter steering a pure 2:1 stream mux from a registered grant
// Ports: clk; rst (synchronous, active-high); bus (mux2_rr_arbiter_if.master) with in0/in1 valid/data/last/ready,
//   out valid/data/last/ready, sel (registered grant, 0 = in0) and busy (grant held).
// MUX2_ARB_PKT_LOCK_EN defined: a grant lasts until the selected packet's last beat; undefined: one beat per grant.
module mux2_rr_arbiter (
    input logic clk,
    input logic rst,
    mux2_rr_arbiter_if.master bus
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_nx;
    logic sel, sel_nx, prio, prio_nx, grant, sel_valid, sel_last, accept, done;
    assign grant     = state == GRANT;
    assign sel_valid = sel ? bus.in1_valid : bus.in0_valid;
    assign sel_last  = sel ? bus.in1_last : bus.in0_last;
    assign accept    = grant & sel_valid & bus.out_ready;
`ifdef MUX2_ARB_PKT_LOCK_EN
    assign done = accept & sel_last;
`else
    assign done = accept;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= 1'b0;
            prio  <= 1'b0;
        end else begin
            state <= state_nx;
            sel   <= sel_nx;
            prio  <= prio_nx;
        end
    end
    // sel is left unchanged when a grant ends so the mux keeps pointing at the last owner through the bubble
    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        prio_nx  = prio;
        if (!grant && (bus.in0_valid || bus.in1_valid)) begin
            state_nx = GRANT;
            sel_nx   = (bus.in0_valid && bus.in1_valid) ? prio : bus.in1_valid;
        end else if (done) begin
            state_nx = IDLE;
            prio_nx  = ~sel;
        end
    end
    assign bus.out_valid = grant & sel_valid;
    assign bus.in0_ready = grant & ~sel & bus.out_ready;
    assign bus.in1_ready = grant & sel & bus.out_ready;
    assign bus.out_data  = sel ? bus.in1_data : bus.in0_data;
    assign bus.out_last  = sel_last;
    assign bus.sel       = sel;
    assign bus.busy      = grant;
endmodule

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

Two-requester round-robin arbiter that owns the select of a 2:1 data mux and shares one downstream valid/ready channel between two upstream streams. Each upstream sends packets of one or more beats, and a packet is granted atomically. The block sits between two producers and a single consumer. It drives the mux select from a registered grant, so the datapath stays a pure combinational 2:1 mux and control is fully synchronous.

## Interface
- `WIDTH`, default 8: data width of each input and of the output.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `in0_valid` input 1: requester 0 has a beat.
- `in0_data` input WIDTH: requester 0 data.
- `in0_last` input 1: final beat of the requester 0 packet.
- `in0_ready` output 1: requester 0 beat accepted this cycle when high with `in0_valid`.
- `in1_valid`, `in1_data`, `in1_last`, `in1_ready`: same as requester 0.
- `out_valid` output 1: downstream beat valid.
- `out_data` output WIDTH: muxed data, `sel ? in1_data : in0_data`.
- `out_last` output 1: muxed last, `sel ? in1_last : in0_last`.
- `out_ready` input 1: downstream accepts the beat.
- `sel` output 1: registered grant and mux select; 0 = requester 0, 1 = requester 1.
- `busy` output 1: high while a grant is held.

## Operation
- FSM states:
  - IDLE: no grant.
  - GRANT: `sel` owns the channel.
- Registers: `state`, `sel`, `prio`. `prio` names the requester that wins a tie.
- IDLE:
  - `out_valid`=0 and both readies are 0.
  - Only in0 valid: `sel`<=0, go to GRANT.
  - Only in1 valid: `sel`<=1, go to GRANT.
  - Both valid: `sel`<=`prio`, go to GRANT.
  - Neither valid: stay in IDLE.
- GRANT:
  - `out_valid` = valid of the selected input.
  - Selected input's ready = `out_ready`.
  - Non-selected ready = 0.
  - The other input's valid is ignored.
- Beat accepted = `out_valid & out_ready`.
- End of grant = accepted beat with the grant-ending condition (see Configuration). On end of grant: go to IDLE, `prio`<=~`sel`. `sel` holds its value.
- Data and last are never registered; the datapath is a pure mux.
- `busy` = (state==GRANT).

## Timing
- Reset values: state=IDLE, `sel`=0, `prio`=0, `busy`=0, `out_valid`=0, `in0_ready`=0, `in1_ready`=0. `out_data` and `out_last` follow in0 (`sel`=0).
- Arbitration latency: a request seen in IDLE at edge N gives `out_valid` in the cycle after edge N. That is one idle cycle from the first valid to the first output.
- Beat throughput: one beat per cycle during a grant while valid and `out_ready` are both high.
- Turnaround: exactly one IDLE bubble cycle after every grant end, even if requests are pending.
- Stalls:
  - Selected valid low in GRANT: `out_valid`=0 and the grant is held.
  - `out_ready` low: selected ready=0; upstream holds data.
- Both requesters continuously valid: grants alternate 0,1,0,1… starting with `prio` (0 after reset).
- Reset asserted mid-packet: next edge returns to the reset values. The partial packet is abandoned, and any beat accepted in the reset cycle counts as transferred.
- Valid and ready are combinational from registered state plus `out_ready`. There is no combinational path from `inX_valid` to `inX_ready`.

## Configuration
- `MUX2_ARB_PKT_LOCK_EN` defined: grant ends on an accepted beat with selected `last`=1. Multi-beat packets are never interleaved.
- `MUX2_ARB_PKT_LOCK_EN` undefined:
  - Grant ends on every accepted beat, giving per-beat round-robin.
  - `in0_last` and `in1_last` are still muxed to `out_last` but do not affect the FSM.

## Test plan
- **Reset check:** hold `rst` for 2 cycles with both valids high → all reset values hold. First edge after release enters GRANT with `sel`=0; `out_valid`=1 the following cycle.
- **Single requester:** in1 sends a 3-beat packet 0xA1,0xA2,0xA3 (last on 0xA3), `out_ready`=1 → `out_data` shows A1,A2,A3 in consecutive cycles with `sel`=1 and `in0_ready`=0 throughout. IDLE follows, then `prio`=0.
- **Lock fairness (LOCK_EN):** both inputs send 2-beat packets continuously → output packet order is in0,in1,in0,in1. No interleaving; one bubble between packets.
- **Backpressure:** `out_ready`=0 for 4 cycles mid-packet → selected ready=0, `out_data` stable, `sel` stable, no beat lost or duplicated.
- **Reset mid-packet:** assert `rst` after beat 1 of a 3-beat in0 packet → next cycle is IDLE with `sel`=0 and `prio`=0. A fresh in1 request is then granted within 2 cycles.
- **Per-beat mode (LOCK_EN undefined):** both inputs valid with `out_ready`=1 → `sel` alternates 0,1,0,1 per accepted beat, with an IDLE cycle between beats.
